// File: rtl/ifetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// IFETCH_PREFETCH_EN adds the PREF state used by the prefetch buffer.
package ifetch_pkg;

    localparam int         AW_DEF       = 8;
    localparam int         IW_DEF       = 8;
    localparam logic [7:0] RESET_PC_DEF = 8'h00;

`ifdef IFETCH_PREFETCH_EN
    typedef enum logic [1:0] {IDLE, REQ, PREF} state_e;
`else
    typedef enum logic {IDLE, REQ} state_e;
`endif

endpackage

// File: rtl/ifetch_pbuf.sv
// One-entry prefetch buffer: data, address tag and valid bit.
// Invalidate has priority over load; hit_o means the entry holds pc_i.
module ifetch_pbuf
    import ifetch_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int IW = IW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          inval_i,
    input  logic [AW-1:0] tag_i,
    input  logic [IW-1:0] data_i,
    input  logic [AW-1:0] pc_i,
    output logic          hit_o,
    output logic [IW-1:0] data_o
);

    logic          valid_q;
    logic [AW-1:0] tag_q;
    logic [IW-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (inval_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            tag_q   <= tag_i;
            data_q  <= data_i;
        end
    end

    assign hit_o  = valid_q && (tag_q == pc_i);
    assign data_o = data_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: PC, req/ack instruction-memory read, registered IR + ir_valid.
// Define IFETCH_PREFETCH_EN to add a one-entry speculative prefetch buffer.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int            AW       = AW_DEF,
    parameter int            IW       = IW_DEF,
    parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEF)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch,
    input  logic          pc_ld,
    input  logic [AW-1:0] pc_in,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [IW-1:0] imem_data,
    output logic [IW-1:0] IR,
    output logic          ir_valid,
    output logic          busy,
    output logic [AW-1:0] pc
);

    // Valid/ready: fetch/pc_ld are taken only when busy=0; imem_req stays
    // high with imem_addr stable until the cycle imem_ack is sampled high.
    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [IW-1:0] ir_q, ir_d;
    logic          irv_q, irv_d;

`ifdef IFETCH_PREFETCH_EN
    logic          pend_q, pend_d;  // demand fetch waiting on the in-flight prefetch
    logic          disc_q, disc_d;  // in-flight prefetch was made stale by pc_ld
    logic          pb_load, pb_inval, pb_hit;
    logic [IW-1:0] pb_data;
    logic          ld_now, fetch_now, discard;

    ifetch_pbuf #(.AW(AW), .IW(IW)) u_pbuf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (pb_load),
        .inval_i (pb_inval),
        .tag_i   (addr_q),
        .data_i  (imem_data),
        .pc_i    (pc_q),
        .hit_o   (pb_hit),
        .data_o  (pb_data)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= '0;
            ir_q    <= '0;
            irv_q   <= 1'b0;
`ifdef IFETCH_PREFETCH_EN
            pend_q  <= 1'b0;
            disc_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            irv_q   <= irv_d;
`ifdef IFETCH_PREFETCH_EN
            pend_q  <= pend_d;
            disc_q  <= disc_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        ir_d    = ir_q;
        irv_d   = 1'b0;
`ifdef IFETCH_PREFETCH_EN
        pend_d    = pend_q;
        disc_d    = disc_q;
        pb_load   = 1'b0;
        pb_inval  = 1'b0;
        ld_now    = !pend_q && pc_ld;
        fetch_now = !pend_q && fetch;
        discard   = disc_q || ld_now;
`endif
        case (state_q)
            IDLE: begin
                if (pc_ld) pc_d = pc_in;
`ifdef IFETCH_PREFETCH_EN
                if (pc_ld) pb_inval = 1'b1;
                if (fetch && !pc_ld && pb_hit) begin
                    ir_d     = pb_data;
                    pc_d     = pc_q + AW'(1);
                    irv_d    = 1'b1;
                    pb_inval = 1'b1;
                    addr_d   = pc_q + AW'(1);
                    pend_d   = 1'b0;
                    disc_d   = 1'b0;
                    state_d  = PREF;
                end else
`endif
                if (fetch) begin
                    addr_d  = pc_ld ? pc_in : pc_q;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    ir_d  = imem_data;
                    pc_d  = addr_q + AW'(1);
                    irv_d = 1'b1;
`ifdef IFETCH_PREFETCH_EN
                    addr_d  = addr_q + AW'(1);
                    pend_d  = 1'b0;
                    disc_d  = 1'b0;
                    state_d = PREF;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef IFETCH_PREFETCH_EN
            PREF: begin
                if (ld_now) begin
                    pc_d     = pc_in;
                    pb_inval = 1'b1;
                end
                if (imem_ack) begin
                    pend_d = 1'b0;
                    disc_d = 1'b0;
                    if (!(pend_q || fetch_now)) begin
                        pb_load = !discard;
                        state_d = IDLE;
                    end else if (!discard) begin
                        // Demand fetch rides on the prefetch: deliver as a hit.
                        ir_d    = imem_data;
                        pc_d    = addr_q + AW'(1);
                        irv_d   = 1'b1;
                        addr_d  = addr_q + AW'(1);
                        state_d = PREF;
                    end else begin
                        addr_d  = ld_now ? pc_in : pc_q;
                        state_d = REQ;
                    end
                end else begin
                    if (ld_now) disc_d = 1'b1;
                    if (fetch_now) pend_d = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        imem_req = (state_q != IDLE);
`ifdef IFETCH_PREFETCH_EN
        busy = (state_q == REQ) || ((state_q == PREF) && pend_q);
`else
        busy = (state_q == REQ);
`endif
    end

    assign imem_addr = addr_q;
    assign IR        = ir_q;
    assign ir_valid  = irv_q;
    assign pc        = pc_q;

endmodule
